// File: rtl/uio_bus_arbiter_pkg.sv
// Shared state encoding, turnaround length and width helper for the uio bus arbiter.
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  localparam int TURN_CYCLES = 1;

  // Bits needed to hold values 0..value-1, never less than one
  function automatic int clog2(input int unsigned value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      result = ((32'd1 << i) < value) ? i + 1 : result;
    end
    return result;
  endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot select of the first asserted request
// at or above ptr, wrapping modulo N_REQ.
module rr_pick
  import uio_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]        pick,
  output logic                    valid
);

  localparam int PTR_W = clog2(N_REQ);

  int best_dist;

  function automatic int wrap_dist(input int idx, input logic [PTR_W-1:0] base);
    return (idx + N_REQ - int'(base)) % N_REQ;
  endfunction

  // Find the nearest asserted request past ptr, then flag only that one
  always_comb begin
    best_dist = N_REQ;
    pick      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      best_dist = (req[i] && (wrap_dist(i, ptr) < best_dist)) ? wrap_dist(i, ptr) : best_dist;
    end
    for (int i = 0; i < N_REQ; i++) begin
      pick[i] = req[i] && (wrap_dist(i, ptr) == best_dist);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pad bus. A dead cycle with all pads input
// separates every ownership change and every direction change of the owner.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int         N_REQ    = 2,
  parameter int         MAX_HOLD = 16,
  parameter logic [7:0] OE_MASK  = 8'hFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   wr,
  input  logic [8*N_REQ-1:0] wdata,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         rdata,
  output logic               rvalid,
  input  logic [7:0]         uio_in,
  output logic [7:0]         uio_out,
  output logic [7:0]         uio_oe,
  output logic               busy
);

  localparam int                 PTR_W     = clog2(N_REQ);
  localparam int                 HOLD_W    = clog2(MAX_HOLD);
  localparam int                 TURN_W    = clog2(TURN_CYCLES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0]  TURN_LAST = TURN_W'(TURN_CYCLES - 1);

  arb_state_e         state_r, state_s;
  logic [N_REQ-1:0]   grant_r, grant_s;
  logic [HOLD_W-1:0]  hold_r, hold_s;
  logic [PTR_W-1:0]   ptr_r, ptr_s, ptr_after_s;
  logic [TURN_W-1:0]  turn_r, turn_s;
  logic               dir_r, dir_s;
  logic [7:0]         uio_out_r, uio_out_s;
  logic [7:0]         uio_oe_r, uio_oe_s;
  logic [7:0]         rdata_r, rdata_s;
  logic               rvalid_r, rvalid_s;
  logic               busy_r;

  logic [N_REQ-1:0]   pick_s;
  logic               pick_valid_s;
  logic               own_req_s, own_wr_s, others_s, release_s;
  logic [7:0]         own_wdata_s;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr_r),
    .pick  (pick_s),
    .valid (pick_valid_s)
  );

  // Owner's write byte and the pointer value that makes the owner lowest priority
  always_comb begin
    own_wdata_s = 8'h00;
    ptr_after_s = ptr_r;
    for (int i = 0; i < N_REQ; i++) begin
      own_wdata_s = own_wdata_s | (wdata[8*i +: 8] & {8{grant_r[i]}});
      ptr_after_s = grant_r[i] ? PTR_W'((i + 1) % N_REQ) : ptr_after_s;
    end
  end

  assign own_req_s = |(req & grant_r);
  assign own_wr_s  = |(wr & grant_r);
  assign others_s  = |(req & ~grant_r);
  assign release_s = !own_req_s || !ena || ((hold_r == HOLD_LAST) && others_s);

  // Next state and next values of every registered output
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    hold_s    = hold_r;
    ptr_s     = ptr_r;
    turn_s    = turn_r;
    dir_s     = dir_r;
    uio_out_s = uio_out_r;
    uio_oe_s  = 8'h00;
    rdata_s   = rdata_r;
    rvalid_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (ena && pick_valid_s) begin
          state_s = OWN;
          grant_s = pick_s;
          hold_s  = '0;
          dir_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      OWN: begin
        if (release_s) begin
          state_s = TURN;
          grant_s = '0;
          ptr_s   = ptr_after_s;
          turn_s  = TURN_LAST;
        end else begin
          hold_s = (hold_r == HOLD_LAST) ? hold_r : hold_r + HOLD_W'(1);
          // A direction change costs one cycle with the pads floating
          if (own_wr_s != dir_r) begin
            dir_s = own_wr_s;
          end else if (own_wr_s) begin
            uio_oe_s  = OE_MASK;
            uio_out_s = own_wdata_s & OE_MASK;
          end else begin
            rdata_s  = uio_in;
            rvalid_s = 1'b1;
          end
        end
      end
      TURN: begin
        if (turn_r == '0) begin
          state_s = IDLE;
        end else begin
          turn_s = turn_r - TURN_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      grant_r   <= '0;
      hold_r    <= '0;
      ptr_r     <= '0;
      turn_r    <= '0;
      dir_r     <= 1'b0;
      uio_out_r <= 8'h00;
      uio_oe_r  <= 8'h00;
      rdata_r   <= 8'h00;
      rvalid_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      hold_r    <= hold_s;
      ptr_r     <= ptr_s;
      turn_r    <= turn_s;
      dir_r     <= dir_s;
      uio_out_r <= uio_out_s;
      uio_oe_r  <= uio_oe_s;
      rdata_r   <= rdata_s;
      rvalid_r  <= rvalid_s;
      busy_r    <= (state_s != IDLE);
    end
  end

  assign grant   = grant_r;
  assign rdata   = rdata_r;
  assign rvalid  = rvalid_r;
  assign uio_out = uio_out_r;
  assign uio_oe  = uio_oe_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: directed scenarios with constant expectations, then
// randomized traffic compared every cycle against a behavioural model of the bus.
module tb_uio_bus_arbiter;

  localparam int         N        = 3;
  localparam int         MAX_HOLD = 4;
  localparam logic [7:0] MASK     = 8'h0F;

  logic           clk = 1'b0;
  logic           rst_n, ena;
  logic [N-1:0]   req, wr;
  logic [8*N-1:0] wdata;
  logic [7:0]     uio_in;
  logic [N-1:0]   grant;
  logic [7:0]     rdata, uio_out, uio_oe;
  logic           rvalid, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner index (-1 = none), cycles owned, last direction, dead cycles left, priority start
  int         m_owner, m_held, m_cool, m_rr;
  logic       m_last_wr;
  logic [N-1:0] e_grant;
  logic [7:0] e_oe, e_out, e_rdata;
  logic       e_rvalid, e_busy;

  uio_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MAX_HOLD), .OE_MASK(MASK)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .wr(wr), .wdata(wdata),
    .grant(grant), .rdata(rdata), .rvalid(rvalid), .uio_in(uio_in),
    .uio_out(uio_out), .uio_oe(uio_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    e_oe     = 8'h00;
    e_rvalid = 1'b0;
    if (!rst_n) begin
      m_owner = -1; m_held = 0; m_cool = 0; m_rr = 0; m_last_wr = 1'b0;
      e_grant = '0; e_out = 8'h00; e_rdata = 8'h00; e_busy = 1'b0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || !ena ||
          (m_held >= MAX_HOLD - 1 && (req & ~(N'(1) << m_owner)) != '0)) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
        m_cool  = 1;
        e_grant = '0;
        e_busy  = 1'b1;
      end else begin
        if (m_held < MAX_HOLD - 1) m_held++;
        if (wr[m_owner] != m_last_wr) begin
          m_last_wr = wr[m_owner];
        end else if (wr[m_owner]) begin
          e_oe  = MASK;
          e_out = wdata[m_owner*8 +: 8] & MASK;
        end else begin
          e_rdata  = uio_in;
          e_rvalid = 1'b1;
        end
        e_busy = 1'b1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
      e_busy = 1'b0;
    end else begin
      e_busy = 1'b0;
      if (ena && req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
        end
        m_held    = 0;
        m_last_wr = 1'b0;
        e_grant   = N'(1) << m_owner;
        e_busy    = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic go_idle();
    req = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; req = 3'b011; wr = '0; wdata = '0; uio_in = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (grant !== 3'b000 || uio_oe !== 8'h00 || rvalid !== 1'b0 || busy !== 1'b0 ||
          uio_out !== 8'h00 || rdata !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_state cycle %0d: grant=%b oe=%h rvalid=%b busy=%b out=%h rdata=%h, want all zero",
                 k, grant, uio_oe, rvalid, busy, uio_out, rdata);
      end
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (grant !== 3'b001 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: grant=%b busy=%b, want 001 1", grant, busy);
    end
    go_idle();
  endtask

  task automatic test_single_write();
    req = 3'b001; wr = 3'b001; wdata = 24'h0000A5;
    tick();
    n_checks++;
    if (grant !== 3'b001 || uio_oe !== 8'h00) begin
      n_fail++; $display("FAIL write_grant: grant=%b oe=%h, want 001 00", grant, uio_oe);
    end
    tick();
    n_checks++;
    if (grant !== 3'b001 || uio_oe !== 8'h00) begin
      n_fail++; $display("FAIL write_turnaround: grant=%b oe=%h, want 001 00", grant, uio_oe);
    end
    tick();
    n_checks++;
    if (uio_oe !== MASK || uio_out !== (8'hA5 & MASK)) begin
      n_fail++; $display("FAIL write_drive: oe=%h out=%h, want %h %h", uio_oe, uio_out, MASK, 8'hA5 & MASK);
    end
    req = '0;
    tick();
    n_checks++;
    if (grant !== 3'b000 || uio_oe !== 8'h00 || busy !== 1'b1) begin
      n_fail++; $display("FAIL write_release_turn: grant=%b oe=%h busy=%b, want 000 00 1", grant, uio_oe, busy);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || grant !== 3'b000) begin
      n_fail++; $display("FAIL write_back_idle: busy=%b grant=%b, want 0 000", busy, grant);
    end
    go_idle();
  endtask

  task automatic test_read();
    req = 3'b010; wr = 3'b000; uio_in = 8'h3C;
    tick();
    n_checks++;
    if (grant !== 3'b010 || rvalid !== 1'b0) begin
      n_fail++; $display("FAIL read_grant: grant=%b rvalid=%b, want 010 0", grant, rvalid);
    end
    tick();
    n_checks++;
    if (rdata !== 8'h3C || rvalid !== 1'b1 || uio_oe !== 8'h00) begin
      n_fail++; $display("FAIL read_data: rdata=%h rvalid=%b oe=%h, want 3c 1 00", rdata, rvalid, uio_oe);
    end
    uio_in = 8'h5A;
    tick();
    n_checks++;
    if (rdata !== 8'h5A || rvalid !== 1'b1) begin
      n_fail++; $display("FAIL read_follow: rdata=%h rvalid=%b, want 5a 1", rdata, rvalid);
    end
    go_idle();
  endtask

  task automatic test_fairness();
    logic [N-1:0] want_g, prev_g;
    logic [7:0]   want_oe;
    int p;
    req = 3'b011; wr = 3'b011; wdata = 24'h005AC3;
    prev_g = '0;
    for (int k = 0; k < 24; k++) begin
      tick();
      p       = k % 12;
      want_g  = (p < 4) ? 3'b001 : ((p >= 6 && p < 10) ? 3'b010 : 3'b000);
      want_oe = (p == 2 || p == 3 || p == 8 || p == 9) ? MASK : 8'h00;
      n_checks++;
      if (grant !== want_g || uio_oe !== want_oe) begin
        n_fail++; $display("FAIL fair_pattern k=%0d: grant=%b oe=%h, want %b %h", k, grant, uio_oe, want_g, want_oe);
      end
      n_checks++;
      if (grant !== prev_g && uio_oe !== 8'h00) begin
        n_fail++; $display("FAIL fair_oe_at_change k=%0d: oe=%h, want 00", k, uio_oe);
      end
      prev_g = grant;
    end
    go_idle();
  endtask

  task automatic test_sole_mask();
    req = 3'b001; wr = 3'b001; wdata = 24'h0000FF;
    for (int k = 0; k < 40; k++) begin
      tick();
      n_checks++;
      if (grant !== 3'b001) begin
        n_fail++; $display("FAIL sole_grant k=%0d: grant=%b, want 001", k, grant);
      end
      if (k >= 2) begin
        n_checks++;
        if (uio_oe !== 8'h0F || uio_out !== 8'h0F) begin
          n_fail++; $display("FAIL sole_mask k=%0d: oe=%h out=%h, want 0f 0f", k, uio_oe, uio_out);
        end
      end
    end
  endtask

  task automatic test_ena_drop();
    ena = 1'b0;
    tick();
    n_checks++;
    if (grant !== 3'b000 || uio_oe !== 8'h00 || busy !== 1'b1) begin
      n_fail++; $display("FAIL ena_turn: grant=%b oe=%h busy=%b, want 000 00 1", grant, uio_oe, busy);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (grant !== 3'b000 || busy !== 1'b0) begin
        n_fail++; $display("FAIL ena_hold_idle k=%0d: grant=%b busy=%b, want 000 0", k, grant, busy);
      end
    end
    ena = 1'b1;
    tick();
    n_checks++;
    if (grant !== 3'b001 || busy !== 1'b1) begin
      n_fail++; $display("FAIL ena_regrant: grant=%b busy=%b, want 001 1", grant, busy);
    end
    go_idle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 5) == 0) wr[i] = ~wr[i];
      end
      wdata  = N*8'($urandom);
      uio_in = 8'($urandom);
      ena    = ($urandom_range(0, 19) != 0);
      rst_n  = ($urandom_range(0, 149) != 0);
      tick();
      n_checks++;
      if (grant !== e_grant || uio_oe !== e_oe || uio_out !== e_out || rdata !== e_rdata ||
          rvalid !== e_rvalid || busy !== e_busy) begin
        n_fail++;
        $display("FAIL random k=%0d: grant=%b oe=%h out=%h rdata=%h rvalid=%b busy=%b, want %b %h %h %h %b %b",
                 k, grant, uio_oe, uio_out, rdata, rvalid, busy,
                 e_grant, e_oe, e_out, e_rdata, e_rvalid, e_busy);
      end
    end
    rst_n = 1'b1; ena = 1'b1;
    go_idle();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; req = '0; wr = '0; wdata = '0; uio_in = 8'h00;
    test_reset();
    test_single_write();
    test_read();
    test_fairness();
    test_sole_mask();
    test_ena_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
